// File: rtl/axis_width_downsizer_if.sv
// AXI-Stream handshake bundle (tvalid/tdata/tready) with manager and subordinate views.
interface axis_if #(
  parameter int TDATA_WIDTH = 32
);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;

  modport m (output tvalid, output tdata, input tready);
  modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_width_downsizer.sv
// Splits each wide AXI-Stream beat into RATIO narrow beats, least-significant lane first,
// refilling on the last-lane handshake so consecutive wide beats stream without a bubble.
module axis_width_downsizer #(
  parameter int unsigned RATIO = 2
) (
  input logic clk,
  input logic rst,
  axis_if.m   axis_mif,
  axis_if.s   axis_sif,
  input logic invalidate
);

  localparam int          W_SIGNED  = axis_mif.TDATA_WIDTH;
  localparam int          SIF_W     = axis_sif.TDATA_WIDTH;
  localparam int unsigned W         = (W_SIGNED > 0) ? unsigned'(W_SIGNED) : 1;
  localparam int unsigned LANE_W    = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  if (RATIO < 2) begin : g_bad_ratio
    $fatal(1, "axis_width_downsizer: RATIO must be >= 2");
  end
  if (W_SIGNED <= 0) begin : g_bad_width
    $fatal(1, "axis_width_downsizer: manager TDATA_WIDTH must be > 0");
  end
  if (SIF_W != int'(RATIO * W)) begin : g_bad_ratio_width
    $fatal(1, "axis_width_downsizer: subordinate TDATA_WIDTH must equal RATIO*W");
  end

  logic [RATIO-1:0][W-1:0] buf_data_q, buf_data_d;
  logic                    buf_valid_q, buf_valid_d;
  logic [LANE_W-1:0]       lane_q, lane_d;

  logic last_c;
  logic m_hs_c;
  logic s_ready_c;
  logic s_hs_c;

  // Handshake decode; upstream ready depends combinationally on downstream ready on the last lane.
  assign last_c    = (lane_q == LAST_LANE);
  assign m_hs_c    = buf_valid_q && axis_mif.tready;
  assign s_ready_c = !rst && !invalidate && (!buf_valid_q || (last_c && axis_mif.tready));
  assign s_hs_c    = axis_sif.tvalid && s_ready_c;

  assign axis_mif.tvalid = buf_valid_q;
  assign axis_mif.tdata  = buf_data_q[lane_q];
  assign axis_sif.tready = s_ready_c;

  // Next state: flush beats refill, refill beats drain, drain beats lane advance.
  always_comb begin
    buf_data_d  = buf_data_q;
    buf_valid_d = buf_valid_q;
    lane_d      = lane_q;
    if (invalidate) begin
      buf_valid_d = 1'b0;
      lane_d      = '0;
    end else if (s_hs_c) begin
      buf_data_d  = axis_sif.tdata;
      buf_valid_d = 1'b1;
      lane_d      = '0;
    end else if (m_hs_c) begin
      if (last_c) begin
        buf_valid_d = 1'b0;
        lane_d      = '0;
      end else begin
        lane_d = lane_q + LANE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_data_q  <= '0;
      buf_valid_q <= 1'b0;
      lane_q      <= '0;
    end else begin
      buf_data_q  <= buf_data_d;
      buf_valid_q <= buf_valid_d;
      lane_q      <= lane_d;
    end
  end

endmodule
